issue_queue_nxm: RTL and testbench

Parametrised collapsing issue queue, successor to the 4-in/1-out queue. Accepts up to DISP renamed micro-ops per cycle and tracks operand readiness via writeback-tag wakeup. Issues up to ISSUE oldest-ready entries per cycle, handles branch-kill squash and full flush, and applies dispatch backpressure. Sits between rename/dispatch and the execution-unit register-read stage.

---
 rtl/issue_queue_nxm_if.sv | 53 +++++
 rtl/issue_queue_nxm.sv | 205 ++++++++++++++++++++
 tb/tb_issue_queue_nxm.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_nxm_if.sv
// ---------------------------------------------------------------------------
// issue_queue_nxm_if
// Signal bundle between rename/dispatch, the writeback wakeup network and
// the register-read stage on one side, and issue_queue_nxm on the other.
//
//   i_disp_valid  DISP            per-lane dispatch valid, contiguous from lane 0
//   i_disp_data   DISP*WIDTH_E    lane k = {payload, brmask, rd, rs2, rs2_rdy, rs1, rs1_rdy}
//   o_disp_ready  1               room for a full DISP-wide dispatch group
//   i_wdest       NWB*WIDTH_REG   writeback destination tags
//   i_wvalid      NWB             per-port wakeup valid
//   i_BrKill      WIDTH_BRM+1     {enKill, BranchMask}
//   i_flush       1               clear all entries and issue valids
//   i_en          1               issue enable
//   o_issue_valid ISSUE           registered per-port issue valid
//   o_issue_data  ISSUE*(WIDTH_E-2) registered entry without ready bits
//   o_count       clog2(SIZE+1)   occupied entries
//
// master = the queue's environment (drives inputs); slave = the queue.
// ---------------------------------------------------------------------------
interface issue_queue_nxm_if #(
    parameter int SIZE      = 16,
    parameter int DISP      = 4,
    parameter int ISSUE     = 2,
    parameter int NWB       = 4,
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH_PL  = 16
);
    localparam int WIDTH_E = 2*WIDTH_REG + WIDTH_REG + WIDTH_BRM + WIDTH_PL + 2;
    localparam int CNT_W   = $clog2(SIZE + 1);

    logic [DISP-1:0]               i_disp_valid;
    logic [DISP*WIDTH_E-1:0]       i_disp_data;
    logic                          o_disp_ready;
    logic [NWB*WIDTH_REG-1:0]      i_wdest;
    logic [NWB-1:0]                i_wvalid;
    logic [WIDTH_BRM:0]            i_BrKill;
    logic                          i_flush;
    logic                          i_en;
    logic [ISSUE-1:0]              o_issue_valid;
    logic [ISSUE*(WIDTH_E-2)-1:0]  o_issue_data;
    logic [CNT_W-1:0]              o_count;

    modport master (
        output i_disp_valid, i_disp_data, i_wdest, i_wvalid, i_BrKill, i_flush, i_en,
        input  o_disp_ready, o_issue_valid, o_issue_data, o_count
    );

    modport slave (
        input  i_disp_valid, i_disp_data, i_wdest, i_wvalid, i_BrKill, i_flush, i_en,
        output o_disp_ready, o_issue_valid, o_issue_data, o_count
    );
endinterface

// File: rtl/issue_queue_nxm.sv
// ---------------------------------------------------------------------------
// issue_queue_nxm
// Collapsing out-of-order issue queue. Entry 0 is the oldest and valid
// entries are always packed at the bottom, so occupancy alone (count_q)
// tells which slots are live. Each cycle:
//   - up to DISP renamed micro-ops are appended after the survivors,
//   - writeback tags set operand ready bits (including dispatching lanes),
//   - up to ISSUE oldest eligible entries are registered onto the issue
//     ports and removed,
//   - branch kill drops matching entries and lanes, flush drops everything.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   io       issue_queue_nxm_if.slave (dispatch, wakeup, kill/flush, issue)
// ---------------------------------------------------------------------------
module issue_queue_nxm #(
    parameter int SIZE      = 16,
    parameter int DISP      = 4,
    parameter int ISSUE     = 2,
    parameter int NWB       = 4,
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH_PL  = 16
) (
    input logic               i_clk,
    input logic               i_rst_n,
    issue_queue_nxm_if.slave  io
);
    localparam int WIDTH_E  = 2*WIDTH_REG + WIDTH_REG + WIDTH_BRM + WIDTH_PL + 2;
    localparam int WIDTH_IO = WIDTH_E - 2;
    localparam int CNT_W    = $clog2(SIZE + 1);

    typedef struct packed {
        logic [WIDTH_PL-1:0]  payload;
        logic [WIDTH_BRM-1:0] brmask;
        logic [WIDTH_REG-1:0] rd;
        logic [WIDTH_REG-1:0] rs2;
        logic                 rs2_rdy;
        logic [WIDTH_REG-1:0] rs1;
        logic                 rs1_rdy;
    } entry_t;

    typedef struct packed {
        logic [WIDTH_PL-1:0]  payload;
        logic [WIDTH_BRM-1:0] brmask;
        logic [WIDTH_REG-1:0] rd;
        logic [WIDTH_REG-1:0] rs2;
        logic [WIDTH_REG-1:0] rs1;
    } issue_t;

    function automatic logic is_killed(input logic [WIDTH_BRM-1:0] brmask,
                                       input logic [WIDTH_BRM:0]   br_kill);
        return br_kill[WIDTH_BRM] && ((brmask & br_kill[WIDTH_BRM-1:0]) != '0);
    endfunction

    function automatic entry_t wake(input entry_t                   e,
                                    input logic [NWB*WIDTH_REG-1:0] wdest,
                                    input logic [NWB-1:0]           wvalid);
        entry_t r;
        r = e;
        for (int w = 0; w < NWB; w++) begin
            if (wvalid[w]) begin
                if (wdest[w*WIDTH_REG +: WIDTH_REG] == e.rs1) r.rs1_rdy = 1'b1;
                if (wdest[w*WIDTH_REG +: WIDTH_REG] == e.rs2) r.rs2_rdy = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic issue_t strip(input entry_t e);
        issue_t r;
        r.payload = e.payload;
        r.brmask  = e.brmask;
        r.rd      = e.rd;
        r.rs2     = e.rs2;
        r.rs1     = e.rs1;
        return r;
    endfunction

    entry_t            entries_q [SIZE];
    entry_t            entries_d [SIZE];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ISSUE-1:0]  issue_valid_q, issue_valid_d;
    issue_t            issue_data_q [ISSUE];
    issue_t            issue_data_d [ISSUE];

    logic [SIZE-1:0]   valid, killed, elig, sel, keep;
    int                elig_rank [SIZE];
    int                keep_pos  [SIZE];
    int                n_elig, n_keep;

    entry_t            lane [DISP];
    logic [DISP-1:0]   lane_ok;
    int                lane_pos [DISP];
    int                n_total;
    logic              disp_ready, disp_fire;

    // Readiness is judged on the pre-issue count; entries leaving this cycle
    // do not make room for the same cycle's dispatch group.
    assign disp_ready = (SIZE - int'(count_q)) >= DISP;

    // Classify every slot: kill, eligibility (on pre-wakeup ready bits, so a
    // woken entry waits one cycle), selection rank, and its collapsed slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        valid  = '0;
        killed = '0;
        elig   = '0;
        sel    = '0;
        keep   = '0;
        n_elig = 0;
        n_keep = 0;
        for (int i = 0; i < SIZE; i++) begin
            valid[i]     = i < int'(count_q);
            killed[i]    = valid[i] && is_killed(entries_q[i].brmask, io.i_BrKill);
            elig[i]      = valid[i] && !killed[i] && entries_q[i].rs1_rdy && entries_q[i].rs2_rdy;
            elig_rank[i] = n_elig;
            sel[i]       = elig[i] && (n_elig < ISSUE);
            if (elig[i]) n_elig = n_elig + 1;
            keep[i]      = valid[i] && !killed[i] && !(sel[i] && io.i_en);
            keep_pos[i]  = n_keep;
            if (keep[i]) n_keep = n_keep + 1;
        end
    end

    // Dispatch lanes land right after the survivors; killed lanes are skipped
    // and the remaining lanes close ranks so the queue stays contiguous.
    always_comb begin
        disp_fire = disp_ready && (io.i_disp_valid != '0) && !io.i_flush;
        n_total   = n_keep;
        lane_ok   = '0;
        for (int k = 0; k < DISP; k++) begin
            lane[k]     = io.i_disp_data[k*WIDTH_E +: WIDTH_E];
            lane_ok[k]  = disp_fire && io.i_disp_valid[k] && !is_killed(lane[k].brmask, io.i_BrKill);
            lane_pos[k] = n_total;
            if (lane_ok[k]) n_total = n_total + 1;
        end
    end

    // Next queue image: each destination slot picks the survivor or lane
    // whose collapsed position equals it. Slots above the new count hold
    // stale contents that count_q masks off.
    always_comb begin
        for (int j = 0; j < SIZE; j++) begin
            entries_d[j] = entries_q[j];
            for (int i = 0; i < SIZE; i++) begin
                if (keep[i] && keep_pos[i] == j)
                    entries_d[j] = wake(entries_q[i], io.i_wdest, io.i_wvalid);
            end
            for (int k = 0; k < DISP; k++) begin
                if (lane_ok[k] && lane_pos[k] == j)
                    entries_d[j] = wake(lane[k], io.i_wdest, io.i_wvalid);
            end
        end
        count_d = io.i_flush ? '0 : CNT_W'(n_total);
    end

    // Issue ports: port p takes the entry of selection rank p. Ports with no
    // selection keep their previous data and drop valid.
    always_comb begin
        issue_valid_d = '0;
        for (int p = 0; p < ISSUE; p++) begin
            issue_data_d[p] = issue_data_q[p];
            if (io.i_en && !io.i_flush) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (sel[i] && elig_rank[i] == p) begin
                        issue_valid_d[p] = 1'b1;
                        issue_data_d[p]  = strip(entries_q[i]);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!i_rst_n) begin
            count_q       <= '0;
            issue_valid_q <= '0;
            for (int p = 0; p < ISSUE; p++) issue_data_q[p] <= '0;
        end else begin
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            for (int p = 0; p < ISSUE; p++) issue_data_q[p] <= issue_data_d[p];
        end
    end

    // NOTE: the entry storage is deliberately not reset; count_q alone
    // decides which slots are live, so clearing the array would only cost
    // reset routing.
    always_ff @(posedge i_clk) begin
        for (int j = 0; j < SIZE; j++) entries_q[j] <= entries_d[j];
    end

    assign io.o_disp_ready  = disp_ready;
    assign io.o_count       = count_q;
    assign io.o_issue_valid = issue_valid_q;

    for (genvar p = 0; p < ISSUE; p++) begin : g_issue_out
        assign io.o_issue_data[p*WIDTH_IO +: WIDTH_IO] = issue_data_q[p];
    end
endmodule

// File: tb/tb_issue_queue_nxm.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_nxm
// Directed scenarios plus a randomized run of issue_queue_nxm, checked
// against a queue-based reference model that applies the queue's rules
// (kill, oldest-ready select, wakeup, append) one clock at a time.
// ---------------------------------------------------------------------------
module tb_issue_queue_nxm;
    localparam int SIZE  = 16;
    localparam int DISP  = 4;
    localparam int ISSUE = 2;
    localparam int NWB   = 4;
    localparam int WR    = 5;
    localparam int WB    = 3;
    localparam int WP    = 16;
    localparam int WE    = 3*WR + WB + WP + 2;
    localparam int WIO   = WE - 2;
    localparam int CW    = $clog2(SIZE + 1);

    typedef struct packed {
        logic [WP-1:0] payload;
        logic [WB-1:0] brmask;
        logic [WR-1:0] rd;
        logic [WR-1:0] rs2;
        logic          rs2_rdy;
        logic [WR-1:0] rs1;
        logic          rs1_rdy;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_queue_nxm_if #(.SIZE(SIZE), .DISP(DISP), .ISSUE(ISSUE), .NWB(NWB),
                         .WIDTH_REG(WR), .WIDTH_BRM(WB), .WIDTH_PL(WP)) io ();

    issue_queue_nxm #(.SIZE(SIZE), .DISP(DISP), .ISSUE(ISSUE), .NWB(NWB),
                      .WIDTH_REG(WR), .WIDTH_BRM(WB), .WIDTH_PL(WP)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io      (io)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t           mq[$];
    logic [ISSUE-1:0] m_valid;
    logic [WIO-1:0] m_data [ISSUE];

    always @(posedge clk) begin
        if (rst_n)
            assert ((io.i_disp_valid & (io.i_disp_valid + 1'b1)) == '0)
            else $error("non-contiguous i_disp_valid %b", io.i_disp_valid);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t exceeded limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic ent_t mk(int rd, int rs1, bit r1, int rs2, bit r2, logic [WB-1:0] bm);
        ent_t e;
        e.payload = WP'(rd * 257 + 3);
        e.brmask  = bm;
        e.rd      = WR'(rd);
        e.rs2     = WR'(rs2);
        e.rs2_rdy = r2;
        e.rs1     = WR'(rs1);
        e.rs1_rdy = r1;
        return e;
    endfunction

    function automatic logic [WR-1:0] port_rd(int p);
        return io.o_issue_data[p*WIO + 2*WR +: WR];
    endfunction

    function automatic logic [WB-1:0] port_bm(int p);
        return io.o_issue_data[p*WIO + 3*WR +: WB];
    endfunction

    task automatic idle();
        io.i_disp_valid = '0;
        io.i_disp_data  = '0;
        io.i_wvalid     = '0;
        io.i_wdest      = '0;
        io.i_BrKill     = '0;
        io.i_flush      = 1'b0;
        io.i_en         = 1'b1;
    endtask

    task automatic put(int k, ent_t e);
        io.i_disp_valid[k]         = 1'b1;
        io.i_disp_data[k*WE +: WE] = e;
    endtask

    task automatic wake_tag(int port, int tag);
        io.i_wvalid[port]         = 1'b1;
        io.i_wdest[port*WR +: WR] = WR'(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid = '0;
        for (int p = 0; p < ISSUE; p++) m_data[p] = '0;
    endtask

    // Advance the model by one clock using the inputs now driven, then clock
    // the DUT and return 1 time unit after the edge.
    task automatic tick();
        ent_t nq[$];
        bit   up [1<<WR];
        int   n_iss = 0;
        bit   kill_en = io.i_BrKill[WB];
        logic [WB-1:0] kmask = io.i_BrKill[WB-1:0];
        bit   room = (SIZE - mq.size()) >= DISP;
        foreach (up[t]) up[t] = 1'b0;
        for (int w = 0; w < NWB; w++)
            if (io.i_wvalid[w]) up[io.i_wdest[w*WR +: WR]] = 1'b1;
        m_valid = '0;
        if (io.i_flush) begin
            mq.delete();
        end else begin
            foreach (mq[i]) begin
                ent_t e = mq[i];
                if (kill_en && ((e.brmask & kmask) != 0)) continue;
                if (io.i_en && e.rs1_rdy && e.rs2_rdy && n_iss < ISSUE) begin
                    m_valid[n_iss] = 1'b1;
                    m_data[n_iss]  = {e.payload, e.brmask, e.rd, e.rs2, e.rs1};
                    n_iss++;
                    continue;
                end
                if (up[e.rs1]) e.rs1_rdy = 1'b1;
                if (up[e.rs2]) e.rs2_rdy = 1'b1;
                nq.push_back(e);
            end
            if (room && io.i_disp_valid != 0) begin
                for (int k = 0; k < DISP; k++) begin
                    if (io.i_disp_valid[k]) begin
                        ent_t ln = io.i_disp_data[k*WE +: WE];
                        if (kill_en && ((ln.brmask & kmask) != 0)) continue;
                        if (up[ln.rs1]) ln.rs1_rdy = 1'b1;
                        if (up[ln.rs2]) ln.rs2_rdy = 1'b1;
                        nq.push_back(ln);
                    end
                end
            end
            mq = nq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (io.o_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", io.o_count); end
        checks++;
        if (io.o_issue_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b want 00", io.o_issue_valid); end
        checks++;
        if (io.o_disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", io.o_disp_ready); end
        checks++;
        if (io.o_issue_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", io.o_issue_data); end
    endtask

    task automatic test_dispatch_issue();
        idle();
        for (int k = 0; k < 4; k++) put(k, mk(k + 1, 1, 1, 2, 1, 3'b000));
        tick();
        checks++;
        if (io.o_count !== CW'(4) || io.o_issue_valid !== 2'b00) begin
            errors++; $display("FAIL disp_first: count=%0d valid=%b want 4/00", io.o_count, io.o_issue_valid);
        end
        idle();
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b11 || port_rd(0) !== 5'd1 || port_rd(1) !== 5'd2 || io.o_count !== CW'(2)) begin
            errors++; $display("FAIL disp_issue1: valid=%b rd=%0d,%0d count=%0d want 11 1,2 2",
                               io.o_issue_valid, port_rd(0), port_rd(1), io.o_count);
        end
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b11 || port_rd(0) !== 5'd3 || port_rd(1) !== 5'd4 || io.o_count !== CW'(0)) begin
            errors++; $display("FAIL disp_issue2: valid=%b rd=%0d,%0d count=%0d want 11 3,4 0",
                               io.o_issue_valid, port_rd(0), port_rd(1), io.o_count);
        end
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b00 || port_rd(0) !== 5'd3) begin
            errors++; $display("FAIL disp_idle: valid=%b rd0=%0d want 00 held 3", io.o_issue_valid, port_rd(0));
        end
    endtask

    task automatic test_wakeup();
        idle();
        put(0, mk(9, 7, 0, 3, 1, 3'b000));    // A waits on tag 7
        put(1, mk(10, 1, 1, 2, 1, 3'b000));   // B ready, younger
        tick();
        checks++;
        if (io.o_count !== CW'(2) || io.o_issue_valid !== 2'b00) begin
            errors++; $display("FAIL wake_disp: count=%0d valid=%b want 2/00", io.o_count, io.o_issue_valid);
        end
        idle();
        wake_tag(0, 7);
        put(0, mk(11, 1, 1, 2, 1, 3'b000));   // C ready
        put(1, mk(12, 4, 1, 7, 0, 3'b000));   // D woken while dispatching
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b01 || port_rd(0) !== 5'd10 || io.o_count !== CW'(3)) begin
            errors++; $display("FAIL wake_edge: valid=%b rd0=%0d count=%0d want 01 10 3",
                               io.o_issue_valid, port_rd(0), io.o_count);
        end
        idle();
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b11 || port_rd(0) !== 5'd9 || port_rd(1) !== 5'd11 || io.o_count !== CW'(1)) begin
            errors++; $display("FAIL wake_issue: valid=%b rd=%0d,%0d count=%0d want 11 9,11 1",
                               io.o_issue_valid, port_rd(0), port_rd(1), io.o_count);
        end
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b01 || port_rd(0) !== 5'd12 || io.o_count !== CW'(0)) begin
            errors++; $display("FAIL wake_lane: valid=%b rd0=%0d count=%0d want 01 12 0",
                               io.o_issue_valid, port_rd(0), io.o_count);
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < 4; c++) begin
            idle();
            for (int k = 0; k < 4; k++) put(k, mk(c*4 + k + 1, (c == 0) ? 20 : 21, 0, 3, 1, 3'b000));
            tick();
        end
        checks++;
        if (io.o_count !== CW'(16) || io.o_disp_ready !== 1'b0) begin
            errors++; $display("FAIL full_fill: count=%0d ready=%b want 16/0", io.o_count, io.o_disp_ready);
        end
        idle();
        for (int k = 0; k < 4; k++) put(k, mk(30 + k, 1, 1, 2, 1, 3'b000));
        tick();
        checks++;
        if (io.o_count !== CW'(16) || io.o_issue_valid !== 2'b00) begin
            errors++; $display("FAIL full_drop: count=%0d valid=%b want 16/00", io.o_count, io.o_issue_valid);
        end
        idle();
        wake_tag(1, 20);
        tick();
        checks++;
        if (io.o_count !== CW'(16) || io.o_disp_ready !== 1'b0) begin
            errors++; $display("FAIL full_wake: count=%0d ready=%b want 16/0", io.o_count, io.o_disp_ready);
        end
        idle();
        tick();
        checks++;
        if (io.o_count !== CW'(14) || io.o_disp_ready !== 1'b0 || port_rd(0) !== 5'd1 || port_rd(1) !== 5'd2) begin
            errors++; $display("FAIL full_issue1: count=%0d ready=%b rd=%0d,%0d want 14 0 1,2",
                               io.o_count, io.o_disp_ready, port_rd(0), port_rd(1));
        end
        idle();
        for (int k = 0; k < 4; k++) put(k, mk(40 + k, 1, 1, 2, 1, 3'b000));
        tick();
        checks++;
        if (io.o_count !== CW'(12) || io.o_disp_ready !== 1'b1 || port_rd(0) !== 5'd3 || port_rd(1) !== 5'd4) begin
            errors++; $display("FAIL full_issue2: count=%0d ready=%b rd=%0d,%0d want 12 1 3,4",
                               io.o_count, io.o_disp_ready, port_rd(0), port_rd(1));
        end
        idle();
        io.i_flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_branch_kill();
        idle();
        put(0, mk(1, 22, 0, 3, 1, 3'b001));
        put(1, mk(2, 22, 0, 3, 1, 3'b010));
        put(2, mk(3, 22, 0, 3, 1, 3'b001));
        put(3, mk(4, 22, 0, 3, 1, 3'b100));
        tick();
        idle();
        put(0, mk(5, 22, 0, 3, 1, 3'b000));
        tick();
        checks++;
        if (io.o_count !== CW'(5)) begin errors++; $display("FAIL kill_fill: count=%0d want 5", io.o_count); end
        idle();
        io.i_BrKill = {1'b1, 3'b001};
        tick();
        checks++;
        if (io.o_count !== CW'(3)) begin errors++; $display("FAIL kill_count: count=%0d want 3", io.o_count); end
        idle();
        wake_tag(2, 22);
        tick();
        idle();
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b11 || port_bm(0) !== 3'b010 || port_rd(0) !== 5'd2 ||
            port_bm(1) !== 3'b100 || port_rd(1) !== 5'd4) begin
            errors++; $display("FAIL kill_order: valid=%b bm=%b,%b rd=%0d,%0d want 11 010,100 2,4",
                               io.o_issue_valid, port_bm(0), port_bm(1), port_rd(0), port_rd(1));
        end
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b01 || port_rd(0) !== 5'd5 || io.o_count !== CW'(0)) begin
            errors++; $display("FAIL kill_last: valid=%b rd0=%0d count=%0d want 01 5 0",
                               io.o_issue_valid, port_rd(0), io.o_count);
        end
        // Kill suppresses an entry that would issue and a dispatching lane.
        idle();
        put(0, mk(6, 1, 1, 2, 1, 3'b010));
        put(1, mk(7, 1, 1, 2, 1, 3'b001));
        tick();
        idle();
        io.i_BrKill = {1'b1, 3'b010};
        put(0, mk(8, 1, 1, 2, 1, 3'b010));
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b01 || port_rd(0) !== 5'd7 || io.o_count !== CW'(0)) begin
            errors++; $display("FAIL kill_issue: valid=%b rd0=%0d count=%0d want 01 7 0",
                               io.o_issue_valid, port_rd(0), io.o_count);
        end
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int k = 0; k < 4; k++) put(k, mk(k + 1, 1, 1, 2, 1, 3'b000));
        tick();
        idle();
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b11 || io.o_count !== CW'(2)) begin
            errors++; $display("FAIL flush_pre: valid=%b count=%0d want 11/2", io.o_issue_valid, io.o_count);
        end
        idle();
        io.i_flush = 1'b1;
        for (int k = 0; k < 4; k++) put(k, mk(k + 5, 1, 1, 2, 1, 3'b000));
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b00 || io.o_count !== CW'(0) || io.o_disp_ready !== 1'b1) begin
            errors++; $display("FAIL flush_edge: valid=%b count=%0d ready=%b want 00 0 1",
                               io.o_issue_valid, io.o_count, io.o_disp_ready);
        end
        idle();
        tick();
        checks++;
        if (io.o_issue_valid !== 2'b00 || io.o_count !== CW'(0)) begin
            errors++; $display("FAIL flush_after: valid=%b count=%0d want 00/0", io.o_issue_valid, io.o_count);
        end
    endtask

    task automatic test_random();
        logic [ISSUE*WIO-1:0] exp_flat;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int n;
            idle();
            io.i_en = ($urandom_range(7) != 0);
            n = $urandom_range(DISP);
            for (int k = 0; k < n; k++) begin
                ent_t e = mk($urandom_range(31), $urandom_range(7), $urandom_range(2) != 0,
                             $urandom_range(7), $urandom_range(2) != 0,
                             ($urandom_range(3) == 0) ? WB'($urandom_range(7)) : 3'b000);
                e.payload = WP'($urandom);
                put(k, e);
            end
            for (int w = 0; w < NWB; w++) if ($urandom_range(3) == 0) wake_tag(w, $urandom_range(7));
            if ($urandom_range(15) == 0) io.i_BrKill = {1'b1, WB'($urandom_range(1, 7))};
            io.i_flush = ($urandom_range(63) == 0);
            tick();
            for (int p = 0; p < ISSUE; p++) exp_flat[p*WIO +: WIO] = m_data[p];
            checks++;
            if (io.o_count !== CW'(mq.size())) begin
                errors++; $display("FAIL rand_count cyc=%0d: got %0d want %0d", cyc, io.o_count, mq.size());
            end
            checks++;
            if (io.o_disp_ready !== ((SIZE - mq.size()) >= DISP)) begin
                errors++; $display("FAIL rand_ready cyc=%0d: got %b for model count %0d", cyc, io.o_disp_ready, mq.size());
            end
            checks++;
            if (io.o_issue_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, io.o_issue_valid, m_valid);
            end
            checks++;
            if (io.o_issue_data !== exp_flat) begin
                errors++; $display("FAIL rand_data cyc=%0d: got %h want %h", cyc, io.o_issue_data, exp_flat);
            end
        end
        idle();
        io.i_flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset_mid_traffic();
        idle();
        for (int k = 0; k < 4; k++) put(k, mk(k + 1, 25, 0, 3, 1, 3'b000));
        tick();
        idle();
        put(0, mk(5, 25, 0, 3, 1, 3'b000));
        put(1, mk(6, 25, 0, 3, 1, 3'b000));
        put(2, mk(7, 1, 1, 2, 1, 3'b000));
        put(3, mk(8, 1, 1, 2, 1, 3'b000));
        tick();
        idle();
        tick();
        checks++;
        if (io.o_count !== CW'(6) || io.o_issue_valid !== 2'b11) begin
            errors++; $display("FAIL rst_pre: count=%0d valid=%b want 6/11", io.o_count, io.o_issue_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (io.o_count !== '0 || io.o_issue_valid !== '0 || io.o_disp_ready !== 1'b1 || io.o_issue_data !== '0) begin
            errors++; $display("FAIL rst_async: count=%0d valid=%b ready=%b data=%h want 0 00 1 0",
                               io.o_count, io.o_issue_valid, io.o_disp_ready, io.o_issue_data);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (io.o_count !== '0 || io.o_issue_valid !== '0) begin
            errors++; $display("FAIL rst_after: count=%0d valid=%b want 0/00", io.o_count, io.o_issue_valid);
        end
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_dispatch_issue();
        test_wakeup();
        test_full();
        test_branch_kill();
        test_flush();
        test_random();
        test_reset_mid_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
